sequence_generator_mn: RTL

- Transmit-side companion of the M×N sequence detector.
- Serialises M back-to-back frames onto a single-bit line. Each frame is N consecutive '1' bits followed by N consecutive '0' bits.
- Each bit is held for BIT_CYC clocks.
- Used as the stimulus/driver end of the detector path; a detector on the same clock must report one detection per complete M-frame burst.

---
 rtl/seq_mn_pkg.sv | 14 +
 rtl/bit_timer.sv | 38 +++
 rtl/sequence_generator_mn.sv | 137 +++++++++++++
 3 files changed

// File: rtl/seq_mn_pkg.sv
// rtl/seq_mn_pkg.sv - shared types and defaults for the MxN sequence generator/detector pair
package seq_mn_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HIGH = 2'd1,
        ST_LOW  = 2'd2
    } seq_state_e;

    localparam int DEF_M_W     = 5;
    localparam int DEF_N_W     = 6;
    localparam int DEF_BIT_CYC = 3;

endpackage

// File: rtl/bit_timer.sv
// rtl/bit_timer.sv - BIT_CYC-clock prescaler producing the per-bit advance enable
module bit_timer
    import seq_mn_pkg::*;
#(
    parameter int BIT_CYC = DEF_BIT_CYC
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic bit_tick
);

    localparam int BC_W = (BIT_CYC > 1) ? $clog2(BIT_CYC) : 1;

    logic [BC_W-1:0] bit_cnt_q;
    logic [BC_W-1:0] bit_cnt_d;

    assign bit_tick = en && (bit_cnt_q == BC_W'(BIT_CYC - 1));

    always_comb begin
        bit_cnt_d = bit_cnt_q;
        if (clr) begin
            bit_cnt_d = '0;
        end else if (en) begin
            bit_cnt_d = bit_tick ? '0 : bit_cnt_q + BC_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bit_cnt_q <= '0;
        end else begin
            bit_cnt_q <= bit_cnt_d;
        end
    end

endmodule

// File: rtl/sequence_generator_mn.sv
// rtl/sequence_generator_mn.sv - serialises M frames of N ones then N zeros, BIT_CYC clocks per bit
module sequence_generator_mn
    import seq_mn_pkg::*;
#(
    parameter int BIT_CYC = DEF_BIT_CYC,
    parameter int M_W     = DEF_M_W,
    parameter int N_W     = DEF_N_W
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic           abort,
    input  logic [M_W-1:0] M,
    input  logic [N_W-1:0] N,
    output logic           data_out,
    output logic           busy,
    output logic           done,
    output logic [M_W-1:0] frame_idx
);

    seq_state_e     state_q, state_d;
    logic [N_W-1:0] run_cnt_q, run_cnt_d;
    logic [M_W-1:0] frame_idx_q, frame_idx_d;
    logic [M_W-1:0] m_r_q, m_r_d;
    logic [N_W-1:0] n_r_q, n_r_d;
    logic           done_q, done_d;
    logic           data_out_q, data_out_d;
    logic           busy_q, busy_d;
    logic           start_acc;
    logic           bit_tick;
    logic           run_end;

    bit_timer #(.BIT_CYC(BIT_CYC)) u_bit_timer (
        .clk      (clk),
        .rst      (rst),
        .clr      (start_acc | abort),
        .en       (state_q != ST_IDLE),
        .bit_tick (bit_tick)
    );

    assign run_end = bit_tick && (run_cnt_q == n_r_q - N_W'(1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            run_cnt_q   <= '0;
            frame_idx_q <= '0;
            m_r_q       <= '0;
            n_r_q       <= '0;
            done_q      <= 1'b0;
            data_out_q  <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            run_cnt_q   <= run_cnt_d;
            frame_idx_q <= frame_idx_d;
            m_r_q       <= m_r_d;
            n_r_q       <= n_r_d;
            done_q      <= done_d;
            data_out_q  <= data_out_d;
            busy_q      <= busy_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        run_cnt_d   = run_cnt_q;
        frame_idx_d = frame_idx_q;
        m_r_d       = m_r_q;
        n_r_d       = n_r_q;
        done_d      = 1'b0;
        start_acc   = 1'b0;
        if (abort && state_q != ST_IDLE) begin
            state_d     = ST_IDLE;
            run_cnt_d   = '0;
            frame_idx_d = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    // abort together with start drops the request, including the empty-burst done
                    if (start && !abort) begin
                        if (M != '0 && N != '0) begin
                            start_acc   = 1'b1;
                            m_r_d       = M;
                            n_r_d       = N;
                            run_cnt_d   = '0;
                            frame_idx_d = '0;
                            state_d     = ST_HIGH;
                        end else begin
                            done_d = 1'b1;
                        end
                    end
                end
                ST_HIGH: begin
                    if (run_end) begin
                        run_cnt_d = '0;
                        state_d   = ST_LOW;
                    end else if (bit_tick) begin
                        run_cnt_d = run_cnt_q + N_W'(1);
                    end
                end
                ST_LOW: begin
                    if (run_end) begin
                        run_cnt_d = '0;
                        if (frame_idx_q == m_r_q - M_W'(1)) begin
                            frame_idx_d = '0;
                            done_d      = 1'b1;
                            state_d     = ST_IDLE;
                        end else begin
                            frame_idx_d = frame_idx_q + M_W'(1);
                            state_d     = ST_HIGH;
                        end
                    end else if (bit_tick) begin
                        run_cnt_d = run_cnt_q + N_W'(1);
                    end
                end
                default: begin
                    state_d     = ST_IDLE;
                    run_cnt_d   = '0;
                    frame_idx_d = '0;
                end
            endcase
        end
    end

    // Line level and busy are registered from the next state so they align with it
    always_comb begin
        data_out_d = (state_d == ST_HIGH);
        busy_d     = (state_d != ST_IDLE);
    end

    assign data_out  = data_out_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign frame_idx = frame_idx_q;

endmodule
